// File: rtl/rle_enc_gen.sv
// Run-length encoder with a selectable active width and a small output FIFO.
// Value words carry MSB=0 and count words carry MSB=1, both within the active width.
module rle_enc_gen #(
    parameter int GROUPS     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                arm,
    input  logic [1:0]          rle_mode,
    input  logic [GROUPS-1:0]   disabledGroups,
    input  logic [8*GROUPS-1:0] dataIn,
    input  logic                validIn,
    output logic                readyIn,
    output logic [8*GROUPS-1:0] dataOut,
    output logic                validOut,
    input  logic                readyOut
);
    localparam int DW  = 8 * GROUPS;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int NGW = $clog2(GROUPS + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          r_state, w_state_nxt;
    logic [NGW-1:0]  r_ngrp, w_live_ngrp, w_ngrp;
    logic [1:0]      r_mode, w_mode;
    logic            r_en_d;
    logic [DW-1:0]   r_ref, r_cnt, w_cnt_nxt, w_ref_nxt;
    logic [DW-1:0]   w_mask, w_low, w_msb, w_cnt_inc;
    logic [DW-1:0]   w_val_in, w_val_ref, w_end_word;
    logic            w_acc, w_fall, w_eq, w_sat, w_flush;
    logic            w_wr0, w_wr1;
    logic [DW-1:0]   w_d0, w_d1;
    logic [DW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wp, r_rp;
    logic [AW:0]     r_occ, w_occ_nxt;
    logic            w_pop, r_ready;

    always_comb begin
        w_live_ngrp = NGW'(GROUPS);
        for (int unsigned g = 0; g < GROUPS; g++)
            if (!disabledGroups[g]) w_live_ngrp = NGW'(g + 1);
    end

    // Live settings are used until enable has been high for a cycle, so the
    // rising-edge cycle latches them and the falling-edge flush still sees the latched ones.
    assign w_ngrp = r_en_d ? r_ngrp : w_live_ngrp;
    assign w_mode = r_en_d ? r_mode : rle_mode;

    always_comb begin
        w_mask = '0;
        for (int unsigned g = 0; g < GROUPS; g++)
            if (g < 32'(w_ngrp)) w_mask[8*g +: 8] = 8'hFF;
    end

    assign w_low      = w_mask >> 1;
    assign w_msb      = w_mask & ~w_low;
    assign w_cnt_inc  = r_cnt + DW'(1);
    assign w_val_in   = dataIn & w_low;
    assign w_val_ref  = r_ref & w_low;
    assign w_end_word = (w_mode == 2'd2 && r_cnt == DW'(1)) ? w_val_ref : (w_msb | (r_cnt & w_low));
    assign w_acc      = validIn & r_ready & arm;
    assign w_fall     = r_en_d & ~enable;
    assign w_eq       = ((dataIn ^ r_ref) & w_mask) == '0;
    assign w_sat      = (w_cnt_inc == w_low);
    assign w_flush    = (r_state == S_RUN) && (r_cnt != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ref   <= '0;
            r_en_d  <= 1'b0;
            r_ngrp  <= NGW'(GROUPS);
            r_mode  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ref   <= w_ref_nxt;
            r_en_d  <= enable;
            r_ngrp  <= w_ngrp;
            r_mode  <= w_mode;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ref_nxt   = r_ref;
        if (!enable || !arm) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_acc) begin
            w_ref_nxt = dataIn;
            if (r_state == S_IDLE || !w_eq) begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = '0;
            end else if (w_sat) begin
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = w_cnt_inc;
            end
        end
    end

    always_comb begin
        w_wr0 = 1'b0;
        w_wr1 = 1'b0;
        w_d0  = '0;
        w_d1  = '0;
        if (w_fall) begin
            if (w_flush) begin
                w_wr0 = 1'b1;
                w_d0  = w_end_word;
                w_wr1 = w_acc;
                w_d1  = dataIn & w_mask;
            end else if (w_acc) begin
                w_wr0 = 1'b1;
                w_d0  = dataIn & w_mask;
            end
        end else if (!enable) begin
            w_wr0 = w_acc;
            w_d0  = dataIn & w_mask;
        end else if (w_acc) begin
            if (r_state == S_IDLE || (!w_eq && r_cnt == '0)) begin
                w_wr0 = 1'b1;
                w_d0  = w_val_in;
            end else if (!w_eq) begin
                w_wr0 = 1'b1;
                w_d0  = w_end_word;
                w_wr1 = 1'b1;
                w_d1  = w_val_in;
            end else if (w_sat) begin
                w_wr0 = 1'b1;
                w_d0  = w_mask;
                w_wr1 = (w_mode == 2'd1);
                w_d1  = w_val_ref;
            end
        end
    end

    assign w_pop     = (r_occ != '0) & readyOut;
    assign w_occ_nxt = r_occ + (AW+1)'(w_wr0) + (AW+1)'(w_wr1) - (AW+1)'(w_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_occ   <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_wr0) r_mem[r_wp] <= w_d0;
            if (w_wr1) r_mem[r_wp + AW'(1)] <= w_d1;
            r_wp    <= r_wp + AW'(w_wr0) + AW'(w_wr1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_occ   <= w_occ_nxt;
            r_ready <= int'(w_occ_nxt) <= FIFO_DEPTH - 2;
        end
    end

    assign readyIn  = r_ready;
    assign validOut = (r_occ != '0);
    assign dataOut  = r_mem[r_rp];

endmodule
